// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read path.
package regfile_pkg;

  localparam int RF_WIDTH    = 16;
  localparam int RF_NREGS    = 16;
  localparam int RF_AW       = 4;
  localparam int RF_ZERO_REG = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    HOLD  = 2'b10
  } rf_state_e;

endpackage

// File: rtl/rf_addr_decoder.sv
// Address to one-hot read-enable decode; the hardwired-zero register is never selected.
module rf_addr_decoder #(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic              en_i,
  input  logic [AW-1:0]     addr_i,
  output logic [NREGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 1; i < NREGS; i++) begin
      onehot_o[i] = en_i && (addr_i == AW'(i));
    end
  end

endmodule

// File: rtl/regfile_read_sequencer.sv
// Two-operand register-file read controller: drives one-hot enables for one cycle,
// samples the bitlines with R0 and write bypass rules, then holds results under valid/ready.
module regfile_read_sequencer
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREGS = RF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     src1,
  input  logic [AW-1:0]     src2,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [NREGS-1:0]  ReadEnable1,
  output logic [NREGS-1:0]  ReadEnable2,
  inout  wire  [WIDTH-1:0]  Bitline1,
  inout  wire  [WIDTH-1:0]  Bitline2,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2
);

  rf_state_e           state_q, state_d;
  logic [AW-1:0]       src1_q, src2_q;
  logic [NREGS-1:0]    re1_d, re2_d, re1_q, re2_q;
  logic [WIDTH-1:0]    data1_q, data2_q, cap1, cap2;
  logic                accept;

  // Bitlines are owned by the register file; this block only listens.
  assign Bitline1 = {WIDTH{1'bz}};
  assign Bitline2 = {WIDTH{1'bz}};

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = DRIVE;
      end
      DRIVE: state_d = HOLD;
      HOLD: begin
        req_ready = rd_ready;
        if (rd_ready) state_d = req_valid ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Enables are decoded from the incoming addresses so they are registered
  // and valid for exactly the DRIVE cycle that follows acceptance.
  rf_addr_decoder #(.NREGS(NREGS), .AW(AW)) u_dec1 (
    .en_i(accept), .addr_i(src1), .onehot_o(re1_d)
  );
  rf_addr_decoder #(.NREGS(NREGS), .AW(AW)) u_dec2 (
    .en_i(accept), .addr_i(src2), .onehot_o(re2_d)
  );

  // A write landing in the DRIVE cycle is not yet visible on the bitline.
  always_comb begin
    if (src1_q == AW'(RF_ZERO_REG))                 cap1 = '0;
    else if (wr_en && (wr_addr == src1_q))          cap1 = wr_data;
    else                                            cap1 = Bitline1;
    if (src2_q == AW'(RF_ZERO_REG))                 cap2 = '0;
    else if (wr_en && (wr_addr == src2_q))          cap2 = wr_data;
    else                                            cap2 = Bitline2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      re1_q   <= '0;
      re2_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      re1_q   <= re1_d;
      re2_q   <= re2_d;
      if (accept) begin
        src1_q <= src1;
        src2_q <= src2;
      end
      if (state_q == DRIVE) begin
        data1_q <= cap1;
        data2_q <= cap2;
      end
    end
  end

  assign ReadEnable1 = re1_q;
  assign ReadEnable2 = re2_q;
  assign rd_valid    = (state_q == HOLD);
  assign rd_data1    = data1_q;
  assign rd_data2    = data2_q;

endmodule
